nios_gpio_irq: RTL and testbench
================================

NIOS_GPIO_IRQ -- requirements
Module: nios_gpio_irq

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH  32  port width in bits, 1..32
  RESET_VALUE  0  reset value of the output data register
  EDGE_TYPE  0  capture mode: 0 rising, 1 falling, 2 any edge
  SYNC_STAGES  2  input synchroniser depth, 2..4
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, all logic on its rising edge
  reset_n  in  1  reset, asynchronous and active-low
  address  in  3  register word offset
  chipselect  in  1  slave select
  write_n  in  1  write strobe, active-low
  writedata  in  32  write data, bits above DATA_WIDTH ignored
  readdata  out  32  read data, zero-latency, zero-extended above DATA_WIDTH
  in_port  in  DATA_WIDTH  asynchronous external inputs
  out_port  out  DATA_WIDTH  output data register
  oe  out  DATA_WIDTH  per-bit output enable (direction register)
  irq  out  1  level interrupt to processor

Function
REQ-003 Register map (word offsets): 0 DATA, 1 DIRECTION, 2 IRQMASK, 3 EDGECAPTURE, 4 OUTSET, 5 OUTCLEAR; offsets 6-7 SHALL read 0 and ignore writes.
REQ-004 Write qualifier SHALL be chipselect & ~write_n; the addressed register updates on the next clk edge.
REQ-005 DATA write SHALL load writedata[DATA_WIDTH-1:0] into the output data register.
REQ-006 OUTSET write SHALL OR writedata into the data register; OUTCLEAR write SHALL AND it with ~writedata; other bits are unchanged.
REQ-007 DATA read SHALL return, per bit, the data register where DIRECTION=1, else the synchronised input.
REQ-008 DIRECTION and IRQMASK SHALL be plain read/write registers; OUTSET/OUTCLEAR SHALL read 0.
REQ-009 out_port SHALL equal the data register; oe SHALL equal DIRECTION; both change one cycle after the write.
REQ-010 in_port SHALL pass through SYNC_STAGES flops, then one previous-sample flop; an edge is a synchronised-vs-previous compare per EDGE_TYPE.
REQ-011 A detected edge SHALL set its EDGECAPTURE bit; latency from an in_port change to the EDGECAPTURE bit set is SYNC_STAGES+1 cycles.
REQ-012 EDGECAPTURE write SHALL clear the bits written 1 (write-1-to-clear); bits written 0 are unchanged.
REQ-013 Simultaneous edge and write-1-clear on the same bit SHALL leave the bit set (edge wins).
REQ-014 Edge detection SHALL run regardless of DIRECTION and IRQMASK.
REQ-015 irq SHALL be the registered value of |(EDGECAPTURE & IRQMASK), asserting one cycle after the contributing bit or mask is set and deasserting one cycle after the last one clears.
REQ-016 readdata SHALL be combinational from address and registers, valid in the same cycle regardless of chipselect; its value is qualified by the master.

Reset
REQ-017 While reset_n is low: data register = RESET_VALUE; DIRECTION, IRQMASK, EDGECAPTURE and irq = 0; sync and previous-sample flops = 0.
REQ-018 Reset assertion SHALL take effect immediately, independent of clk, including mid-write; release SHALL be synchronous to clk by the system reset controller.
REQ-019 The first cycle after release SHALL NOT produce a false edge from the reset-cleared previous sample for falling or any-edge modes; the previous sample loads without detection for SYNC_STAGES+1 cycles.

Structure
REQ-020 Shared package nios_gpio_pkg SHALL hold register offset constants and the EDGE_TYPE encoding constants.
REQ-021 Synchroniser plus edge detector SHALL be one sub-module, nios_gpio_sync, parametrised by width, stages and edge type; it outputs the synchronised value and a per-bit edge pulse.
REQ-022 Implementation SHALL hold no latches and no combinational loops; readdata is the only combinational output.

Verification
REQ-023 Reset with RESET_VALUE=0xA5, DATA_WIDTH=8: out_port=0xA5, oe=0, irq=0, and reads of offsets 1-3 return 0.
REQ-024 Write DATA=0xF0, OUTSET=0x03, OUTCLEAR=0x10: out_port=0xE3; DIRECTION=0xFF, then DATA read returns 0x000000E3.
REQ-025 EDGE_TYPE=0, IRQMASK=0x01: in_port bit0 0->1 -> EDGECAPTURE=0x01 after 3 cycles and irq high 1 cycle later; write 0x01 to EDGECAPTURE -> irq low 1 cycle after the clear.
REQ-026 Bit0 rising edge detected in the same cycle as an EDGECAPTURE write of 0x01 -> EDGECAPTURE bit0 remains 1 and irq stays high.
REQ-027 EDGE_TYPE=2: pulse bit3 high for 1 cycle then low 5 cycles later -> EDGECAPTURE=0x08; IRQMASK=0 -> irq stays 0; later writing IRQMASK=0x08 -> irq rises 1 cycle after.
REQ-028 Assert reset_n low mid-write and between clk edges -> all registers return to reset values asynchronously; no irq glitch after release.

Source files
------------

// File: rtl/nios_gpio_pkg.sv
// Shared register map and edge-mode encodings for the NIOS GPIO block.
package nios_gpio_pkg;

  typedef enum logic [2:0] {
    REG_DATA        = 3'd0,
    REG_DIRECTION   = 3'd1,
    REG_IRQMASK     = 3'd2,
    REG_EDGECAPTURE = 3'd3,
    REG_OUTSET      = 3'd4,
    REG_OUTCLEAR    = 3'd5,
    REG_RSVD6       = 3'd6,
    REG_RSVD7       = 3'd7
  } reg_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_gpio_sync.sv
// Multi-stage input synchroniser followed by a previous-sample edge detector.
module nios_gpio_sync
  import nios_gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  localparam logic [2:0] WARM_DONE = 3'(STAGES + 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       warm_q;
  logic [WIDTH-1:0] raw_edge;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
      if (warm_q != WARM_DONE) warm_q <= warm_q + 3'd1;
    end
  end

  assign sync_o = sync_q[STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: raw_edge = ~sync_o & prev_q;
      EDGE_ANY:  raw_edge = sync_o ^ prev_q;
      default:   raw_edge = sync_o & ~prev_q;
    endcase
  end

  // Until the pipeline has refilled after reset, prev_q holds reset zeros, not a real sample.
  assign edge_o = (warm_q == WARM_DONE) ? raw_edge : '0;

endmodule

// File: rtl/nios_gpio_irq.sv
// Avalon-MM GPIO port: output data/direction registers, edge capture and masked level irq.
module nios_gpio_irq
  import nios_gpio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  reg_addr_e             addr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] in_sync, in_edge;
  logic [DATA_WIDTH-1:0] ecap_clr, rdata;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] ecap_q, ecap_d;
  logic                  irq_q, irq_d;

  assign addr  = reg_addr_e'(address);
  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];

  nios_gpio_sync #(
    .WIDTH     (DATA_WIDTH),
    .STAGES    (SYNC_STAGES),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk_i   (clk),
    .rst_n_i (reset_n),
    .async_i (in_port),
    .sync_o  (in_sync),
    .edge_o  (in_edge)
  );

  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    mask_d   = mask_q;
    ecap_clr = '0;
    if (wr_en) begin
      case (addr)
        REG_DATA:        data_d   = wdata;
        REG_DIRECTION:   dir_d    = wdata;
        REG_IRQMASK:     mask_d   = wdata;
        REG_EDGECAPTURE: ecap_clr = wdata;
        REG_OUTSET:      data_d   = data_q | wdata;
        REG_OUTCLEAR:    data_d   = data_q & ~wdata;
        default:         ;
      endcase
    end
    // Set is applied after clear so a same-cycle edge survives a write-1-to-clear.
    ecap_d = (ecap_q & ~ecap_clr) | in_edge;
    irq_d  = |(ecap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
      ecap_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      ecap_q <= ecap_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_DATA:        rdata = (data_q & dir_q) | (in_sync & ~dir_q);
      REG_DIRECTION:   rdata = dir_q;
      REG_IRQMASK:     rdata = mask_q;
      REG_EDGECAPTURE: rdata = ecap_q;
      default:         rdata = '0;
    endcase
    readdata = 32'(rdata);
  end

  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_gpio_irq.sv
// Bench: three GPIO instances (rising/2 stages, falling/3, any-edge/4) on a shared bus vs. a history-based model.
module tb_nios_gpio_irq;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] rd     [NI];
  logic [7:0]  op     [NI];
  logic [7:0]  oe_v   [NI];
  logic        irq_v  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    nios_gpio_irq #(
      .DATA_WIDTH  (8),
      .RESET_VALUE (8'hA5),
      .EDGE_TYPE   (g),
      .SYNC_STAGES (g + 2)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (rd[g]),
      .in_port    (in_port),
      .out_port   (op[g]),
      .oe         (oe_v[g]),
      .irq        (irq_v[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference model: register contents plus a history of in_port samples, newest first.
  logic [7:0] m_data, m_dir, m_mask;
  logic [7:0] m_ecap [NI];
  logic       m_irq  [NI];
  logic [7:0] m_hist [$];

  task automatic model_reset();
    m_data = 8'hA5; m_dir = 8'h00; m_mask = 8'h00;
    for (int i = 0; i < NI; i++) begin m_ecap[i] = 8'h00; m_irq[i] = 1'b0; end
    m_hist.delete();
  endtask

  function automatic logic [7:0] sync_val(int i);
    int s = i + 2;
    if (m_hist.size() >= s) return m_hist[s-1];
    return 8'h00;
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [2:0] a);
    case (a)
      3'd0: return {24'h0, (m_data & m_dir) | (sync_val(i) & ~m_dir)};
      3'd1: return {24'h0, m_dir};
      3'd2: return {24'h0, m_mask};
      3'd3: return {24'h0, m_ecap[i]};
      default: return 32'h0;
    endcase
  endfunction

  // An input change is visible to the edge compare only once it has aged past
  // the synchroniser; nothing is compared until s+2 samples exist after reset.
  task automatic model_step();
    logic       wr;
    logic [7:0] wd, clr, nw, od, ev;
    wr = chipselect && !write_n;
    wd = writedata[7:0];
    m_hist.push_front(in_port);
    if (m_hist.size() > 8) void'(m_hist.pop_back());
    clr = (wr && address == 3'd3) ? wd : 8'h00;
    for (int i = 0; i < NI; i++) begin
      int s = i + 2;
      ev = 8'h00;
      if (m_hist.size() >= s + 2) begin
        nw = m_hist[s];
        od = m_hist[s+1];
        case (i)
          0:       ev = nw & ~od;
          1:       ev = ~nw & od;
          default: ev = nw ^ od;
        endcase
      end
      m_irq[i]  = |(m_ecap[i] & m_mask);
      m_ecap[i] = (m_ecap[i] & ~clr) | ev;
    end
    if (wr) begin
      case (address)
        3'd0: m_data = wd;
        3'd1: m_dir  = wd;
        3'd2: m_mask = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] want;
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    in_port = 8'hFF;
    reset_n = 1'b0; model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      total++; if (op[i] !== 8'hA5) begin bad++; $display("FAIL reset_out inst%0d got %h want a5", i, op[i]); end
      total++; if (oe_v[i] !== 8'h00) begin bad++; $display("FAIL reset_oe inst%0d got %h want 00", i, oe_v[i]); end
      total++; if (irq_v[i] !== 1'b0) begin bad++; $display("FAIL reset_irq inst%0d got %b want 0", i, irq_v[i]); end
    end
    for (int a = 1; a < 8; a++) begin
      if (a == 4 || a == 5) continue;
      address = 3'(a); #1;
      for (int i = 0; i < NI; i++) begin
        total++; if (rd[i] !== 32'h0) begin bad++; $display("FAIL reset_rd%0d inst%0d got %h want 0", a, i, rd[i]); end
      end
    end
    address = 3'd3;
    repeat (8) tick();
    for (int i = 0; i < NI; i++) begin
      total++; if (rd[i] !== 32'h0) begin bad++; $display("FAIL no_false_edge inst%0d got %h want 0", i, rd[i]); end
    end
    in_port = 8'h00;
    repeat (8) tick();
    for (int i = 0; i < NI; i++) begin
      want = (i == 0) ? 8'h00 : 8'hFF;
      total++; if (rd[i] !== {24'h0, want}) begin bad++; $display("FAIL fall_capture inst%0d got %h want %h", i, rd[i], want); end
    end
    bus_write(3'd3, 32'hFF);
    for (int i = 0; i < NI; i++) begin
      total++; if (rd[i] !== 32'h0) begin bad++; $display("FAIL w1c_all inst%0d got %h want 0", i, rd[i]); end
    end
  endtask

  task automatic test_data_regs();
    bus_write(3'd0, 32'hF0);
    bus_write(3'd4, 32'h03);
    bus_write(3'd5, 32'h10);
    for (int i = 0; i < NI; i++) begin
      total++; if (op[i] !== 8'hE3) begin bad++; $display("FAIL set_clr_out inst%0d got %h want e3", i, op[i]); end
      total++; if (oe_v[i] !== 8'h00) begin bad++; $display("FAIL oe_before_dir inst%0d got %h want 00", i, oe_v[i]); end
    end
    bus_write(3'd1, 32'hFF);
    address = 3'd0; #1;
    for (int i = 0; i < NI; i++) begin
      total++; if (oe_v[i] !== 8'hFF) begin bad++; $display("FAIL dir_oe inst%0d got %h want ff", i, oe_v[i]); end
      total++; if (rd[i] !== 32'h000000E3) begin bad++; $display("FAIL data_rd inst%0d got %h want 000000e3", i, rd[i]); end
    end
    bus_write(3'd0, 32'hFFFF_FF5A);
    bus_write(3'd6, 32'hFFFF_FFFF);
    chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h11;
    tick();
    write_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      total++; if (rd[i] !== 32'h0000005A) begin bad++; $display("FAIL wide_wr_rd inst%0d got %h want 0000005a", i, rd[i]); end
    end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      for (int i = 0; i < NI; i++) begin
        total++; if (rd[i] !== 32'h0) begin bad++; $display("FAIL wo_rd%0d inst%0d got %h want 0", a, i, rd[i]); end
      end
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] we;
    logic        wi;
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    address = 3'd3;
    in_port = 8'h01;
    for (int c = 1; c <= 4; c++) begin
      tick();
      we = (c >= 3) ? 32'h1 : 32'h0;
      wi = (c >= 4);
      total++; if (rd[0] !== we) begin bad++; $display("FAIL rise_lat c%0d got %h want %h", c, rd[0], we); end
      total++; if (irq_v[0] !== wi) begin bad++; $display("FAIL irq_lat c%0d got %b want %b", c, irq_v[0], wi); end
    end
    bus_write(3'd3, 32'h01);
    total++; if (rd[0] !== 32'h0) begin bad++; $display("FAIL w1c got %h want 0", rd[0]); end
    total++; if (irq_v[0] !== 1'b1) begin bad++; $display("FAIL irq_hold_after_clr got %b want 1", irq_v[0]); end
    tick();
    total++; if (irq_v[0] !== 1'b0) begin bad++; $display("FAIL irq_drop got %b want 0", irq_v[0]); end
  endtask

  task automatic test_collision();
    in_port = 8'h00; repeat (4) tick();
    in_port = 8'h01; repeat (4) tick();
    total++; if (irq_v[0] !== 1'b1) begin bad++; $display("FAIL coll_pre_irq got %b want 1", irq_v[0]); end
    in_port = 8'h00; repeat (4) tick();
    in_port = 8'h01; tick(); tick();
    bus_write(3'd3, 32'h01);
    total++; if (rd[0] !== 32'h1) begin bad++; $display("FAIL edge_wins got %h want 1", rd[0]); end
    total++; if (rd[0] !== exp_rd(0, 3'd3)) begin bad++; $display("FAIL edge_wins_model got %h want %h", rd[0], exp_rd(0, 3'd3)); end
    for (int c = 0; c < 3; c++) begin
      total++; if (irq_v[0] !== 1'b1) begin bad++; $display("FAIL coll_irq c%0d got %b want 1", c, irq_v[0]); end
      tick();
    end
  endtask

  task automatic test_any_edge();
    repeat (8) tick();
    bus_write(3'd2, 32'h00);
    bus_write(3'd3, 32'hFF);
    address = 3'd3;
    in_port = 8'h09; tick();
    in_port = 8'h01; repeat (8) tick();
    total++; if (rd[2] !== 32'h08) begin bad++; $display("FAIL any_pulse got %h want 08", rd[2]); end
    total++; if (irq_v[2] !== 1'b0) begin bad++; $display("FAIL any_masked_irq got %b want 0", irq_v[2]); end
    for (int i = 0; i < NI; i++) begin
      total++; if (rd[i] !== exp_rd(i, 3'd3)) begin bad++; $display("FAIL pulse_model inst%0d got %h want %h", i, rd[i], exp_rd(i, 3'd3)); end
    end
    bus_write(3'd2, 32'h08);
    total++; if (irq_v[2] !== 1'b0) begin bad++; $display("FAIL mask_irq_early got %b want 0", irq_v[2]); end
    tick();
    total++; if (irq_v[2] !== 1'b1) begin bad++; $display("FAIL mask_irq_rise got %b want 1", irq_v[2]); end
  endtask

  task automatic test_async_reset();
    bus_write(3'd1, 32'h3C);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h3C;
    #3;
    reset_n = 1'b0; model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      total++; if (op[i] !== 8'hA5) begin bad++; $display("FAIL areset_out inst%0d got %h want a5", i, op[i]); end
      total++; if (oe_v[i] !== 8'h00) begin bad++; $display("FAIL areset_oe inst%0d got %h want 00", i, oe_v[i]); end
      total++; if (irq_v[i] !== 1'b0) begin bad++; $display("FAIL areset_irq inst%0d got %b want 0", i, irq_v[i]); end
    end
    chipselect = 1'b0; write_n = 1'b1; address = 3'd3; in_port = 8'h5A;
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        total++; if (irq_v[i] !== 1'b0 || rd[i] !== 32'h0) begin
          bad++; $display("FAIL post_release c%0d inst%0d irq=%b ecap=%h want 0/0", c, i, irq_v[i], rd[i]);
        end
      end
    end
    total++; if (op[0] !== 8'hA5) begin bad++; $display("FAIL write_dropped got %h want a5", op[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 9) > 3);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ 8'($urandom);
      tick();
      for (int i = 0; i < NI; i++) begin
        total++; if (op[i] !== m_data) begin bad++; $display("FAIL rnd_out n%0d inst%0d got %h want %h", n, i, op[i], m_data); end
        total++; if (oe_v[i] !== m_dir) begin bad++; $display("FAIL rnd_oe n%0d inst%0d got %h want %h", n, i, oe_v[i], m_dir); end
        total++; if (irq_v[i] !== m_irq[i]) begin bad++; $display("FAIL rnd_irq n%0d inst%0d got %b want %b", n, i, irq_v[i], m_irq[i]); end
        total++; if (rd[i] !== exp_rd(i, address)) begin
          bad++; $display("FAIL rnd_rd n%0d inst%0d addr%0d got %h want %h", n, i, address, rd[i], exp_rd(i, address));
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    model_reset();
    test_reset();
    test_data_regs();
    test_edge_irq();
    test_collision();
    test_any_edge();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
